// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Arbitrates two requesters onto one shared combinational ALU. One
//   operation is in flight at a time and walks IDLE -> EXEC -> RESP -> IDLE.
//   Operands are captured when the request is accepted. The ALU result is
//   captured in EXEC and held on the shared response bus until the owning
//   requester takes it.
//
//   Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration
//   of simultaneous requests. Without it, requester 0 has fixed priority and
//   there is no pointer register.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   rN_valid / rN_ready              request handshake, N = 0,1 (ready is combinational in IDLE)
//   rN_ctrl, rN_sign, rN_a, rN_b     request payload: opcode, signed select, operands
//   rspN_valid / rspN_ready          response handshake for requester N
//   rsp_data, rsp_zero, rsp_err      shared response bus (err = opcode beyond slt)
//   alu_ctrl, alu_sign, alu_in1/2    drive to the shared ALU, from the operand registers only
//   alu_out, alu_zero                combinational ALU result
module alu_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [4:0]        r0_ctrl,
    input  logic              r0_sign,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [4:0]        r1_ctrl,
    input  logic              r1_sign,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,

    output logic [4:0]        alu_ctrl,
    output logic              alu_sign,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero
);

    localparam int unsigned CTRL_W = 5;
    // Highest defined opcode (slt); anything above is flagged as an error.
    localparam logic [CTRL_W-1:0] LAST_OP = CTRL_W'(9);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              sign;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    op_t  op_q;       // operands of the in-flight operation
    op_t  op_sel;     // payload of the requester that wins this cycle
    logic owner_q;    // requester owning the in-flight operation (1 = r1)
    logic pick1;      // requester 1 wins arbitration this cycle
    logic accept;     // a request is accepted on the coming edge
    logic rsp_done;   // owner takes its response on the coming edge

    // Arbitration: which requester wins when the FSM is idle.
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_q;     // requester granted most recently (1 = r1)

    always_comb begin
        pick1 = r1_valid & (~r0_valid | ~last_q);
    end

    // Pointer follows every accept; reset value favours r0 first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= pick1;
        end
    end
`else
    always_comb begin
        pick1 = r1_valid & ~r0_valid;
    end
`endif

    always_comb begin
        accept   = (state == S_IDLE) & (r0_valid | r1_valid);
        rsp_done = (state == S_RESP) & (owner_q ? rsp1_ready : rsp0_ready);
    end

    // Payload mux from the winning requester.
    always_comb begin
        if (pick1) begin
            op_sel.ctrl = r1_ctrl;
            op_sel.sign = r1_sign;
            op_sel.a    = r1_a;
            op_sel.b    = r1_b;
        end else begin
            op_sel.ctrl = r0_ctrl;
            op_sel.sign = r0_sign;
            op_sel.a    = r0_a;
            op_sel.b    = r0_b;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                next_state = S_RESP;
            end
            S_RESP: begin
                if (rsp_done) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // FSM outputs. Ready is gated by rst_n so it drops the moment reset asserts.
    always_comb begin
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            S_IDLE: begin
                r0_ready = rst_n & r0_valid & ~pick1;
                r1_ready = rst_n & pick1;
            end
            S_RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
            end
            default: begin
                r0_ready   = 1'b0;
                r1_ready   = 1'b0;
            end
        endcase
    end

    // Operand capture at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            owner_q <= 1'b0;
        end else if (accept) begin
            op_q    <= op_sel;
            owner_q <= pick1;
        end
    end

    // Result capture in EXEC; held through RESP until the owner takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
            rsp_err  <= (op_q.ctrl > LAST_OP);
        end
    end

    // Shared ALU sees only the captured operands.
    assign alu_ctrl = op_q.ctrl;
    assign alu_sign = op_q.sign;
    assign alu_in1  = op_q.a;
    assign alu_in2  = op_q.b;

endmodule
